icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have ports: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have ports: addr  input  16  CPU fetch word address (pc).
REQ-004 SHALL have ports: rd_en  input  1  CPU fetch request.
REQ-005 SHALL have ports: flush  input  1  invalidate all lines (one-cycle pulse).
REQ-006 SHALL have ports: instr  output  16  fetched instruction, valid when hit=1.
REQ-007 SHALL have ports: hit  output  1  rd_en & valid line & tag match & state IDLE.
REQ-008 SHALL have ports: stall  output  1  rd_en & ~hit; CPU holds pc and IF/ID while high.
REQ-009 SHALL have ports: mem_addr  output  16  backing-memory word address.
REQ-010 SHALL have ports: mem_re  output  1  backing-memory read request, held until beat accepted.
REQ-011 SHALL have ports: mem_rdata  input  16  backing-memory read data.
REQ-012 SHALL have ports: mem_rvalid  input  1  mem_rdata valid this cycle; one beat per pulse.
REQ-013 SHALL have parameters: LINES, default 16, number of lines; WORDS, default 4, words per line.

Function
REQ-014 SHALL be direct-mapped: offset=addr[1:0], index=addr[5:2], tag=addr[15:6] (10 bits) at defaults.
REQ-015 SHALL hold per line: valid bit, 10-bit tag, WORDS x 16-bit data.
REQ-016 SHALL compute hit, instr and stall combinationally from addr and array contents (zero-cycle hit latency).
REQ-017 SHALL drive instr = 16'h0000 when hit=0.
REQ-018 SHALL implement FSM states IDLE, FILL, DONE.
REQ-019 IDLE: on rd_en & ~hit & ~flush, latch addr[15:2] as miss line, clear beat counter, go FILL.
REQ-020 FILL: mem_re=1, mem_addr={miss line, beat[1:0]}; each mem_rvalid writes mem_rdata to data[index][beat] and increments beat.
REQ-021 FILL: on the 4th mem_rvalid (beat==3) write tag, set valid (unless abort set), go DONE.
REQ-022 DONE: one cycle, mem_re=0, stall=1; go IDLE; next cycle the held addr hits.
REQ-023 Miss penalty SHALL be 4 mem_rvalid beats + 2 cycles; no critical-word-first.
REQ-024 mem_re SHALL be 0 in IDLE and DONE; mem_rvalid outside FILL SHALL be ignored.
REQ-025 Fill SHALL use the latched miss line; addr changes during FILL SHALL NOT alter mem_addr.
REQ-026 flush in IDLE SHALL clear all valid bits on that edge; a same-cycle miss SHALL NOT start a fill.
REQ-027 flush during FILL SHALL clear all valid bits and set abort; remaining beats are consumed, the filled line is left invalid, abort cleared on entering IDLE.
REQ-028 flush in DONE SHALL clear all valid bits; FSM still returns to IDLE and re-misses.
REQ-029 rd_en=0 SHALL force hit=0 and stall=0 in IDLE; in FILL/DONE stall=1 regardless of rd_en.
REQ-030 Beat counter SHALL be 2 bits and wrap 3->0 only on fill completion.

Reset
REQ-031 rst_n low SHALL asynchronously set state IDLE, beat=0, abort=0, all valid=0.
REQ-032 Outputs during/after reset: hit=0, stall=0 (until rd_en), instr=0, mem_re=0, mem_addr=0.
REQ-033 Reset mid-FILL SHALL abandon the fill; late mem_rvalid after release SHALL be ignored.
REQ-034 Tag and data arrays SHALL NOT require reset.

Structure
REQ-035 LINES, WORDS, tag/index/offset widths and FSM state encoding SHALL live in shared package cpu_pkg.
REQ-036 Tag/valid storage with flush-clear SHALL be sub-module icache_tags; data array and FSM in icache.

Verification
REQ-037 Cold miss: reset, addr=16'h0040, rd_en=1, mem returns 16'hA000..A003 -> mem_addr 0040..0043, stall until DONE+1, then instr=16'hA000, hit=1.
REQ-038 Hit sweep: after REQ-037, addr=0041,0042,0043 -> instr A001,A002,A003 each same cycle, stall=0, mem_re=0.
REQ-039 Conflict: addr=16'h0440 (same index, tag differs) -> miss, refill; then addr=0040 misses again.
REQ-040 Flush in FILL: flush at beat 2 of miss to 0080 -> 4 beats consumed, line invalid, addr=0080 re-misses.
REQ-041 Slow memory: mem_rvalid gaps of 0-5 cycles and addr toggled during FILL -> mem_addr stays on latched line, data correct.
REQ-042 Reset mid-FILL: rst_n low at beat 1, stray mem_rvalid after release -> state IDLE, mem_re=0, addr=0040 misses.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared cache geometry, address field widths and fill FSM encoding
package cpu_pkg;
  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 16 - IDX_W - OFF_W;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_e;
endpackage

// File: rtl/icache_tags.sv
// icache_tags: per-line valid bits (reset, flash-clear on flush) and untimed tag store; ports: rd_idx_i->rd_valid_o/rd_tag_o, wr_* line update, flush_i clears all valids
module icache_tags import cpu_pkg::*; #(
  parameter int LINES = cpu_pkg::LINES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_valid_i,
  input  logic             flush_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  // flush beats a coincident line write so a line completing on a flush edge stays invalid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (flush_i) valid_q <= '0;
    else if (wr_en_i) valid_q[wr_idx_i] <= wr_valid_i;
  always_ff @(posedge clk)
    if (wr_en_i) tag_q[wr_idx_i] <= wr_tag_i;
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, zero-cycle hit, blocking line fill; ports: CPU side addr/rd_en/flush -> instr/hit/stall, memory side mem_addr/mem_re <- mem_rdata/mem_rvalid
module icache import cpu_pkg::*; #(
  parameter int LINES = cpu_pkg::LINES,
  parameter int WORDS = cpu_pkg::WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        rd_en,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        hit,
  output logic        stall,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);
  localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);
  state_e state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic abort_q, abort_d;
  logic [15-OFF_W:0] line_q, line_d;
  logic [15:0] data_q [LINES][WORDS];
  logic t_valid;
  logic [TAG_W-1:0] t_tag;
  logic [IDX_W-1:0] idx, fill_idx;
  logic beat_acc, fill_last;
  assign idx = addr[OFF_W+IDX_W-1:OFF_W];
  assign fill_idx = line_q[IDX_W-1:0];
  assign beat_acc = state_q == ST_FILL && mem_rvalid;
  assign fill_last = beat_acc && beat_q == LAST;
  // an aborted fill still writes the tag but leaves the line invalid
  icache_tags #(.LINES(LINES)) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (idx),
    .wr_en_i   (fill_last),
    .wr_idx_i  (fill_idx),
    .wr_tag_i  (line_q[15-OFF_W:IDX_W]),
    .wr_valid_i(~abort_q),
    .flush_i   (flush),
    .rd_valid_o(t_valid),
    .rd_tag_o  (t_tag)
  );
  assign hit = rd_en && state_q == ST_IDLE && t_valid && t_tag == addr[15:16-TAG_W];
  assign instr = hit ? data_q[idx][addr[OFF_W-1:0]] : '0;
  assign stall = (rd_en && !hit) || state_q != ST_IDLE;
  assign mem_re = state_q == ST_FILL;
  assign mem_addr = mem_re ? {line_q, beat_q} : '0;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    abort_d = abort_q;
    line_d = line_q;
    if (state_q == ST_IDLE && rd_en && !hit && !flush) begin
      state_d = ST_FILL;
      line_d = addr[15:OFF_W];
      beat_d = '0;
    end
    if (state_q == ST_FILL) begin
      abort_d = abort_q | flush;
      beat_d = mem_rvalid ? beat_q + 1'b1 : beat_q;
      state_d = fill_last ? ST_DONE : ST_FILL;
    end
    if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
      abort_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q <= '0;
      abort_q <= 1'b0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      abort_q <= abort_d;
      line_q <= line_d;
    end
  always_ff @(posedge clk)
    if (beat_acc) data_q[fill_idx][beat_q] <= mem_rdata;
endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache with a background memory responder
module tb_icache;
  logic clk = 0, rst_n = 0, rd_en = 0, flush = 0, mem_rvalid = 0;
  logic [15:0] addr = 0, mem_rdata = 0;
  logic [15:0] instr, mem_addr;
  logic hit, stall, mem_re;
  int n_vec = 0, n_err = 0;
  logic [15:0] sb [$];
  bit resp_en = 1;
  int max_gap = 0, gap_cnt = 0, rbeat = 0;
  logic [13:0] exp_line = 0;

  icache dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en), .flush(flush),
    .instr(instr), .hit(hit), .stall(stall), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memval(input logic [15:0] a);
    return a ^ 16'hA040;
  endfunction

  // memory model: one beat per request slot, random gaps, checks the fill address
  always begin
    logic [15:0] want;
    @(posedge clk);
    #1;
    if (resp_en) begin
      mem_rvalid = 0;
      if (mem_re) begin
        if (gap_cnt == 0) begin
          want = {exp_line, rbeat[1:0]};
          n_vec++;
          if (mem_addr !== want) begin
            n_err++;
            $display("FAIL mem_addr: got %h want %h", mem_addr, want);
          end
          mem_rdata = memval(mem_addr);
          mem_rvalid = 1;
          rbeat++;
          gap_cnt = $urandom_range(max_gap, 0);
        end else gap_cnt--;
      end
    end
  end

  task automatic fetch(input logic [15:0] a, input bit exp_miss, input int gap, input bit toggle);
    int waited = 0;
    logic [15:0] exp;
    addr = a; rd_en = 1; exp_line = a[15:2]; rbeat = 0; max_gap = gap; gap_cnt = 0;
    sb.push_back(memval(a));
    #1;
    while (!hit && waited < 300) begin
      n_vec++;
      if (stall !== 1'b1) begin n_err++; $display("FAIL stall_on_miss %h: got %b want 1", a, stall); end
      @(posedge clk);
      #1;
      addr = (toggle && mem_re) ? 16'($urandom) : a;
      #1;
      waited++;
    end
    n_vec++;
    if (hit !== 1'b1) begin n_err++; $display("FAIL hit_timeout %h: got %b want 1", a, hit); end
    n_vec++;
    if ((waited != 0) !== exp_miss) begin n_err++; $display("FAIL miss_flag %h: got %b want %b", a, waited != 0, exp_miss); end
    n_vec++;
    if (rbeat !== (exp_miss ? 4 : 0)) begin n_err++; $display("FAIL beats %h: got %0d want %0d", a, rbeat, exp_miss ? 4 : 0); end
    if (exp_miss && gap == 0) begin
      n_vec++;
      if (waited != 6) begin n_err++; $display("FAIL penalty %h: got %0d want 6", a, waited); end
    end
    exp = sb.pop_front();
    n_vec++;
    if (instr !== exp) begin n_err++; $display("FAIL instr %h: got %h want %h", a, instr, exp); end
    n_vec++;
    if ({stall, mem_re} !== 2'b00) begin n_err++; $display("FAIL hit_idle %h: got stall/mem_re %b want 00", a, {stall, mem_re}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({hit, stall, instr, mem_re, mem_addr} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got hit %b stall %b instr %h mem_re %b mem_addr %h want all 0", hit, stall, instr, mem_re, mem_addr);
    end
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hit_sweep;
    for (int i = 1; i < 4; i++) fetch(16'h0040 + 16'(i), 0, 0, 0);
  endtask

  task automatic test_rd_en_low;
    addr = 16'h0041; rd_en = 0;
    #1;
    n_vec++;
    if ({hit, stall, instr} !== 18'd0) begin n_err++; $display("FAIL rd_en_low: got hit %b stall %b instr %h want 0", hit, stall, instr); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_idle;
    addr = 16'h0200; rd_en = 1; flush = 1;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL flush_idle_stall: got %b want 1", stall); end
    @(posedge clk);
    #1;
    flush = 0; rd_en = 0;
    n_vec++;
    if (mem_re !== 1'b0) begin n_err++; $display("FAIL flush_idle_nofill: got mem_re %b want 0", mem_re); end
    @(posedge clk);
    #1;
    fetch(16'h0040, 1, 0, 0);
  endtask

  task automatic test_flush_fill;
    int t = 0;
    addr = 16'h0080; rd_en = 1; exp_line = 14'h0020; rbeat = 0; max_gap = 0; gap_cnt = 0;
    while (rbeat != 3 && t < 50) begin @(posedge clk); #2; t++; end
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    #1;
    t = 0;
    while (mem_re && t < 50) begin @(posedge clk); #2; t++; end
    n_vec++;
    if (rbeat !== 4) begin n_err++; $display("FAIL flush_fill_beats: got %0d want 4", rbeat); end
    n_vec++;
    if ({hit, stall} !== 2'b01) begin n_err++; $display("FAIL flush_fill_done: got hit/stall %b want 01", {hit, stall}); end
    @(posedge clk);
    #2;
    n_vec++;
    if ({hit, stall, mem_re} !== 3'b010) begin n_err++; $display("FAIL flush_fill_invalid: got hit/stall/mem_re %b want 010", {hit, stall, mem_re}); end
    rd_en = 0;
    @(posedge clk);
    #1;
    fetch(16'h0080, 1, 0, 0);
  endtask

  task automatic test_reset_fill;
    int t = 0;
    addr = 16'h0040; rd_en = 1; exp_line = 14'h0010; rbeat = 0; max_gap = 0; gap_cnt = 0;
    while (rbeat != 2 && t < 50) begin @(posedge clk); #2; t++; end
    rst_n = 0; resp_en = 0; mem_rvalid = 0; rd_en = 0;
    #1;
    n_vec++;
    if ({hit, stall, instr, mem_re, mem_addr} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_fill_async: got hit %b stall %b instr %h mem_re %b mem_addr %h want 0", hit, stall, instr, mem_re, mem_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1; mem_rvalid = 1; mem_rdata = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if ({mem_re, stall} !== 2'b00) begin n_err++; $display("FAIL stray_rvalid %0d: got mem_re/stall %b want 00", i, {mem_re, stall}); end
    end
    mem_rvalid = 0; resp_en = 1;
    @(posedge clk);
    #1;
    fetch(16'h0040, 1, 0, 0);
  endtask

  initial begin
    test_reset;
    fetch(16'h0040, 1, 0, 0);
    test_hit_sweep;
    test_rd_en_low;
    fetch(16'h0440, 1, 0, 0);
    fetch(16'h0040, 1, 0, 0);
    test_flush_idle;
    test_flush_fill;
    fetch(16'h0100, 1, 5, 1);
    for (int i = 1; i < 4; i++) fetch(16'h0100 + 16'(i), 0, 0, 0);
    test_reset_fill;
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
